// File: rtl/scroll_display_driver_pkg.sv
// scroll_display_driver_pkg: char codes, message ROM and display constants shared by the scroll display driver
package scroll_display_driver_pkg;
  typedef enum logic {BLANK, DRIVE} state_e;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] ANODES_OFF = 4'hF;
  localparam logic [3:0] CH_0 = 4'd0, CH_1 = 4'd1, CH_2 = 4'd2, CH_3 = 4'd3;
  localparam logic [3:0] CH_4 = 4'd4, CH_5 = 4'd5, CH_6 = 4'd6, CH_7 = 4'd7;
  localparam logic [3:0] CH_8 = 4'd8, CH_9 = 4'd9, CH_A = 4'd10, CH_B = 4'd11;
  localparam logic [3:0] CH_C = 4'd12, CH_D = 4'd13, CH_E = 4'd14, CH_SP = 4'd15;
  localparam logic [3:0] MSG_ROM [16] = '{CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7,
                                          CH_8, CH_9, CH_A, CH_B, CH_C, CH_D, CH_E, CH_SP};
endpackage

// File: rtl/scroll_display_driver_char_seg_decoder.sv
// char_seg_decoder: char code to active-low {g,f,e,d,c,b,a} segments
module char_seg_decoder
  import scroll_display_driver_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (code_i)
      CH_0:    seg_o = 7'h40;
      CH_1:    seg_o = 7'h79;
      CH_2:    seg_o = 7'h24;
      CH_3:    seg_o = 7'h30;
      CH_4:    seg_o = 7'h19;
      CH_5:    seg_o = 7'h12;
      CH_6:    seg_o = 7'h02;
      CH_7:    seg_o = 7'h78;
      CH_8:    seg_o = 7'h00;
      CH_9:    seg_o = 7'h10;
      CH_A:    seg_o = 7'h08;
      CH_B:    seg_o = 7'h03;
      CH_C:    seg_o = 7'h46;
      CH_D:    seg_o = 7'h21;
      CH_E:    seg_o = 7'h06;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/scroll_display_driver.sv
// scroll_display_driver: multiplexes 4 message chars onto a common-anode 7-seg display with blanking gaps
module scroll_display_driver
  import scroll_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] base_addr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0] digit_q, digit_d;
  logic [3:0] frame_addr_q, frame_addr_d, rom_q, rom_d, idx, an_d;
  logic [6:0] shadow_q, shadow_d, dec, seg_d;
  logic wrap, latch;
  state_e state_q, state_d;
  char_seg_decoder u_dec (.code_i(rom_q), .seg_o(dec));
  // ROM data is ready one cycle into the slot; the shadow captures it on the last blank cycle
  always_comb begin
    wrap = slot_cnt_q == CW'(REFRESH_DIV - 1);
    latch = slot_cnt_q == '0 && digit_q == 2'd3;
    slot_cnt_d = wrap ? '0 : slot_cnt_q + CW'(1);
    digit_d = wrap ? digit_q - 2'd1 : digit_q;
    frame_addr_d = latch ? base_addr : frame_addr_q;
    idx = frame_addr_d + {2'b00, ~digit_q};
    rom_d = slot_cnt_q == '0 ? MSG_ROM[idx] : rom_q;
    shadow_d = slot_cnt_q == CW'(BLANK_CYCLES - 1) ? dec : shadow_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BLANK;
    else state_q <= state_d;
  end
  always_comb state_d = slot_cnt_d < CW'(BLANK_CYCLES) ? BLANK : DRIVE;
  always_comb begin
    an_d = state_d == DRIVE ? ~(4'b0001 << digit_d) : ANODES_OFF;
    seg_d = state_d == DRIVE ? shadow_d : SEG_BLANK;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= '0;
      digit_q <= 2'd3;
      frame_addr_q <= '0;
      rom_q <= CH_SP;
      shadow_q <= SEG_BLANK;
      an <= ANODES_OFF;
      seg <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q <= digit_d;
      frame_addr_q <= frame_addr_d;
      rom_q <= rom_d;
      shadow_q <= shadow_d;
      an <= an_d;
      seg <= seg_d;
      frame_start <= latch;
    end
  end
endmodule

// File: tb/tb_scroll_display_driver.sv
// tb_scroll_display_driver: checks the scroll display driver against a cycle-indexed reference model
module tb_scroll_display_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] base_addr = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame_start;
  int tests = 0;
  int fails = 0;
  int k = 0;
  int fb = 0;
  logic [3:0] prev_an = 4'hF;
  logic [6:0] prev_seg = 7'h7F;
  logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00};
  scroll_display_driver #(.REFRESH_DIV(10), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr),
    .an(an), .seg(seg), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask
  // Cycle k counts rising edges since reset release; a frame is 40 cycles, a slot 10, the first 2 blank
  task automatic step();
    int pos, d;
    logic [3:0] ea;
    logic [6:0] es;
    if (k % 40 == 0) fb = base_addr;
    pos = k % 10;
    d = 3 - (k / 10) % 4;
    ea = pos < 2 ? 4'hF : ~(4'b0001 << d);
    es = pos < 2 ? 7'h7F : ~seg_hi[(fb + 3 - d) % 16];
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("frame_start", frame_start, k % 40 == 1);
    chk("one_cold", $countones(~an) <= 1, 1);
    if (prev_an != 4'hF && an != 4'hF) chk("seg_hold", seg, prev_seg);
    prev_an = an;
    prev_seg = seg;
    @(negedge clk);
    k++;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    repeat (40) step();
    base_addr = 4'd14;
    repeat (40) step();
    base_addr = 4'd0;
    repeat (25) step();
    base_addr = 4'd5;
    repeat (55) step();
    repeat (15) step();
    #2 reset = 1'b1;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_fs", frame_start, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    prev_an = 4'hF;
    prev_seg = 7'h7F;
    repeat (400) begin
      base_addr = 4'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
